disp_src_sel: RTL and testbench
===============================

// Module: disp_src_sel
// PURPOSE
//  Registered, parametrised display-source selector for the digital-clock display path.
//  Selects one of NUM_CH BCD digit groups (time, alarm, stopwatch, ...) for the display scanner.
//  Adds button-driven browsing, a force override and auto-return to channel 0 after inactivity.
//  Adds blinking of the digit under edit. Sits between the counter blocks and the 7-seg scan driver.
// PARAMETERS
//  NUM_CH      3         number of source channels, >=2; channel 0 = home (time of day)
//  DIGITS      4         BCD digits per channel, 4 bits each (tens digits zero-extended upstream)
//  TIMEOUT_CYC 50000000  idle cycles in BROWSE before auto-return to channel 0, >=2
//  BLINK_CYC   25000000  cycles per blink half-period, >=1
//  CH_W        $clog2(NUM_CH)  derived, not overridden
// PORTS
//  mclk        in   1               system clock; all logic on rising edge
//  rst         in   1               asynchronous, active-high reset
//  ch_data     in   NUM_CH*DIGITS*4 channel k occupies bits [k*DIGITS*4 +: DIGITS*4]
//  btn_next    in   1               single-cycle pulse (debounced upstream): advance channel
//  force_en    in   1               level: override browsing, show force_ch
//  force_ch    in   CH_W            channel shown while force_en=1
//  edit_en     in   1               level: blink digit edit_idx
//  edit_idx    in   $clog2(DIGITS)  digit index under edit, 0 = least significant
//  disp_data   out  DIGITS*4        selected digits, registered
//  disp_blank  out  DIGITS          1 = scanner must blank that digit
//  cur_ch      out  CH_W            channel currently driving disp_data
//  ch_chg      out  1               one-cycle pulse when cur_ch changes
// BEHAVIOUR
//  Reset: state=HOME, cur_ch=0, disp_data=0, disp_blank=0, ch_chg=0, idle_cnt=0, blink_cnt=0, blink_ph=1 (on).
//  FSM states HOME, BROWSE, FORCE (encoding in package).
//   HOME:   sel=0. btn_next -> BROWSE, sel=1. force_en -> FORCE.
//   BROWSE: btn_next -> sel+1; sel=NUM_CH-1 wraps to 0 and enters HOME.
//           idle_cnt clears on btn_next, else increments; idle_cnt=TIMEOUT_CYC-1 -> HOME.
//           force_en -> FORCE.
//   FORCE:  sel=force_ch; btn_next ignored; force_en falls -> HOME (browse position not kept).
//   Priority in any state: force_en > btn_next > timeout.
//   force_ch >= NUM_CH is clamped to 0.
//  Latency: ch_data, sel and blink changes reach disp_data/disp_blank on the next mclk edge (1 cycle).
//   cur_ch and disp_data update on the same edge; ch_chg=1 on that edge only if cur_ch differs from previous.
//  Blink: blink_cnt free-runs 0..BLINK_CYC-1; at terminal count blink_ph toggles.
//   blink_cnt restarts at 0 with blink_ph=1 on any edit_en rising edge or edit_idx change.
//   disp_blank[edit_idx] = edit_en & ~blink_ph; other bits 0. edit_idx >= DIGITS blanks nothing.
//   Blink runs in every state; data of the blanked digit is still output.
//  Counters sized $clog2(TIMEOUT_CYC), $clog2(BLINK_CYC); no overflow past terminal count.
//  Reset asserted mid-operation: immediate return to reset values, async; no partial update after release.
// STRUCTURE
//  Package disp_pkg: state enum {HOME, BROWSE, FORCE}; DIGIT_W=4 localparam.
//  One sub-module: disp_blink_gen (blink_cnt, blink_ph, restart detect; outputs blink_ph).
//  Top holds FSM, idle counter, channel mux, output registers.
// TESTING (NUM_CH=3, DIGITS=4, TIMEOUT_CYC=8, BLINK_CYC=4 in bench)
//  1 Reset, ch0=16'h1234 -> cycle after rst falls: disp_data=16'h1234, cur_ch=0, disp_blank=0, ch_chg=0.
//  2 btn_next x3, ch1=16'h0630, ch2=16'h0059 -> cur_ch 1,2,0, disp 0630,0059,1234; ch_chg 1 cycle after each pulse.
//  3 One btn_next then idle -> cur_ch=1 for 8 cycles, then 0 with ch_chg=1; btn_next at idle 6 restarts count.
//  4 force_en=1, force_ch=2, btn_next pulsed same cycle -> cur_ch=2, pulse ignored; force_ch=3 -> cur_ch=0; force_en=0 -> HOME.
//  5 edit_en=1, edit_idx=2 -> disp_blank 4'b0000 x4 cycles, 4'b0100 x4, repeat; edit_idx->0 restarts with 4 unblanked cycles.
//  6 rst pulsed mid-BROWSE with idle_cnt=5 -> outputs zero asynchronously; after release HOME, full 8-cycle timeout.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display-source selector and its blink generator.
package disp_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        HOME   = 2'd0,
        BROWSE = 2'd1,
        FORCE  = 2'd2
    } disp_state_e;

    // Counter/index width that never collapses to zero bits for degenerate sizes.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_blink_gen.sv
// Blink phase generator for the digit under edit.
// Restarts in the visible phase whenever edit mode is entered or the edited digit moves.
module disp_blink_gen
    import disp_pkg::*;
#(
    parameter int BLINK_CYC = 25000000,
    parameter int IDX_W     = 2
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             edit_en,
    input  logic [IDX_W-1:0] edit_idx,
    output logic             blink_ph
);

    localparam int               CNT_W    = width_of(BLINK_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ph_q;
    logic             ph_nxt;
    logic             en_q;
    logic [IDX_W-1:0] idx_q;
    logic             restart;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        restart = (edit_en & ~en_q) | (edit_idx != idx_q);
        cnt_nxt = blink_cnt + 1'b1;
        ph_nxt  = ph_q;
        if (restart) begin
            cnt_nxt = '0;
            ph_nxt  = 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            ph_nxt  = ~ph_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            ph_q      <= 1'b1;
            en_q      <= 1'b0;
            idx_q     <= '0;
        end else begin
            blink_cnt <= cnt_nxt;
            ph_q      <= ph_nxt;
            en_q      <= edit_en;
            idx_q     <= edit_idx;
        end
    end

    // Phase the coming edge will hold; the top registers blanking from it so blanking lines up with the phase.
    assign blink_ph = ph_nxt;

endmodule

// File: rtl/disp_src_sel.sv
// Registered display-source selector: browsing, force override, inactivity return to channel 0,
// and blinking of the digit under edit.
module disp_src_sel
    import disp_pkg::*;
#(
    parameter  int NUM_CH      = 3,
    parameter  int DIGITS      = 4,
    parameter  int TIMEOUT_CYC = 50000000,
    parameter  int BLINK_CYC   = 25000000,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int IDX_W       = width_of(DIGITS)
) (
    input  logic                              mclk,
    input  logic                              rst,
    input  logic [NUM_CH*DIGITS*DIGIT_W-1:0]  ch_data,
    input  logic                              btn_next,
    input  logic                              force_en,
    input  logic [CH_W-1:0]                   force_ch,
    input  logic                              edit_en,
    input  logic [IDX_W-1:0]                  edit_idx,
    output logic [DIGITS*DIGIT_W-1:0]         disp_data,
    output logic [DIGITS-1:0]                 disp_blank,
    output logic [CH_W-1:0]                   cur_ch,
    output logic                              ch_chg
);

    localparam int                GRP_W     = DIGITS * DIGIT_W;
    localparam int                IDLE_W    = width_of(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    disp_state_e       state;
    disp_state_e       state_nxt;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   force_sel;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;
    logic [GRP_W-1:0]  grp [NUM_CH];
    logic              blink_ph;
    logic [DIGITS-1:0] blank_nxt;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_grp
        assign grp[k] = ch_data[k*GRP_W +: GRP_W];
    end

    // Out-of-range force requests fall back to the home channel.
    assign force_sel = (int'(force_ch) >= NUM_CH) ? '0 : force_ch;

    disp_blink_gen #(
        .BLINK_CYC (BLINK_CYC),
        .IDX_W     (IDX_W)
    ) u_blink (
        .mclk     (mclk),
        .rst      (rst),
        .edit_en  (edit_en),
        .edit_idx (edit_idx),
        .blink_ph (blink_ph)
    );

    // Next state, next channel and idle count; sel is the channel the coming edge will show.
    always_comb begin
        state_nxt = state;
        sel       = cur_ch;
        idle_nxt  = '0;
        if (force_en) begin
            state_nxt = FORCE;
            sel       = force_sel;
        end else begin
            case (state)
                HOME: begin
                    if (btn_next) begin
                        state_nxt = BROWSE;
                        sel       = CH_W'(1);
                    end else begin
                        sel = '0;
                    end
                end
                BROWSE: begin
                    if (btn_next) begin
                        if (cur_ch == LAST_CH) begin
                            state_nxt = HOME;
                            sel       = '0;
                        end else begin
                            sel = cur_ch + 1'b1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_nxt = HOME;
                        sel       = '0;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
                default: begin
                    // Leaving FORCE drops any earlier browse position.
                    state_nxt = HOME;
                    sel       = '0;
                end
            endcase
        end
    end

    always_comb begin
        blank_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank_nxt[i] = edit_en & ~blink_ph & (int'(edit_idx) == i);
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state      <= HOME;
            cur_ch     <= '0;
            idle_cnt   <= '0;
            disp_data  <= '0;
            disp_blank <= '0;
            ch_chg     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_ch     <= sel;
            idle_cnt   <= idle_nxt;
            disp_data  <= grp[sel];
            disp_blank <= blank_nxt;
            ch_chg     <= (sel != cur_ch);
        end
    end

endmodule

// File: tb/tb_disp_src_sel.sv
// Scoreboard bench for disp_src_sel: stimulus pushes model predictions, a monitor pops and compares.
module tb_disp_src_sel;

    localparam int NUM_CH      = 3;
    localparam int DIGITS      = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int BLINK_CYC   = 4;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic [47:0] ch_data;
    logic        btn_next;
    logic        force_en;
    logic [1:0]  force_ch;
    logic        edit_en;
    logic [1:0]  edit_idx;
    logic [15:0] disp_data;
    logic [3:0]  disp_blank;
    logic [1:0]  cur_ch;
    logic        ch_chg;

    disp_src_sel #(
        .NUM_CH      (NUM_CH),
        .DIGITS      (DIGITS),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .BLINK_CYC   (BLINK_CYC)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .ch_data    (ch_data),
        .btn_next   (btn_next),
        .force_en   (force_en),
        .force_ch   (force_ch),
        .edit_en    (edit_en),
        .edit_idx   (edit_idx),
        .disp_data  (disp_data),
        .disp_blank (disp_blank),
        .cur_ch     (cur_ch),
        .ch_chg     (ch_chg)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  blank;
        logic [1:0]  ch;
        logic        chg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: mode 0 home, 1 browse, 2 force; blink phase from cycles since last restart.
    int         mode, pos, prev_pos, idle, edge_n, origin;
    logic       prev_en;
    logic [1:0] prev_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mode     = 0;
        pos      = 0;
        prev_pos = 0;
        idle     = 0;
        edge_n   = 0;
        origin   = -1;
        prev_en  = 1'b0;
        prev_idx = 2'd0;
    endtask

    task automatic model_edge();
        exp_t e;
        bit   restart;
        bit   ph_on;
        int   fc;
        if (force_en) begin
            mode = 2;
            fc   = int'(force_ch);
            pos  = (fc < NUM_CH) ? fc : 0;
            idle = 0;
        end else if (mode == 2) begin
            mode = 0;
            pos  = 0;
            idle = 0;
        end else if (btn_next) begin
            pos  = pos + 1;
            idle = 0;
            if (pos == NUM_CH) begin
                pos  = 0;
                mode = 0;
            end else begin
                mode = 1;
            end
        end else if (mode == 1) begin
            if (idle == TIMEOUT_CYC - 1) begin
                mode = 0;
                pos  = 0;
                idle = 0;
            end else begin
                idle++;
            end
        end
        restart = (edit_en && !prev_en) || (edit_idx != prev_idx);
        if (restart) origin = edge_n;
        ph_on   = (((edge_n - origin) / BLINK_CYC) % 2) == 0;
        e.data  = ch_data[pos*16 +: 16];
        e.blank = (edit_en && !ph_on) ? 4'(1 << edit_idx) : 4'b0000;
        e.ch    = 2'(pos);
        e.chg   = (pos != prev_pos);
        prev_pos = pos;
        prev_en  = edit_en;
        prev_idx = edit_idx;
        edge_n++;
        exp_q.push_back(e);
    endtask

    // Entered at a falling edge: drive, predict the next rising edge, then move to the next falling edge.
    task automatic step(input bit b, input bit fe, input logic [1:0] fc, input bit ee, input logic [1:0] ei);
        btn_next = b;
        force_en = fe;
        force_ch = fc;
        edit_en  = ee;
        edit_idx = ei;
        model_edge();
        @(negedge mclk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, force_en, force_ch, edit_en, edit_idx);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_data"}, disp_data, 0);
        check({tag, "_rst_ch"}, cur_ch, 0);
        check({tag, "_rst_blank"}, disp_blank, 0);
        check({tag, "_rst_chg"}, ch_chg, 0);
        model_reset();
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge mclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("disp_data", disp_data, e.data);
                check("disp_blank", disp_blank, e.blank);
                check("cur_ch", cur_ch, e.ch);
                check("ch_chg", ch_chg, e.chg);
            end
        end
    end

    initial begin : stimulus
        bit fe, ee;
        logic [1:0] ei;
        ch_data  = {16'h0059, 16'h0630, 16'h1234};
        btn_next = 1'b0;
        force_en = 1'b0;
        force_ch = 2'd0;
        edit_en  = 1'b0;
        edit_idx = 2'd0;
        @(negedge mclk);
        @(negedge mclk);
        check("init_data", disp_data, 0);
        check("init_ch", cur_ch, 0);
        check("init_blank", disp_blank, 0);
        check("init_chg", ch_chg, 0);
        rst = 1'b0;
        model_reset();

        // Home after reset
        hold(2);
        // Browse through all channels and wrap home
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
            hold(2);
        end
        // Inactivity return, then a press at idle 6 restarting the count
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        hold(10);
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        hold(6);
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        hold(10);
        // Force override with a simultaneous press, out-of-range channel, release
        step(1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
        hold(2);
        step(1'b1, 1'b1, 2'd3, 1'b0, 2'd0);
        hold(2);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        hold(2);
        // Blink of digit 2, then move to digit 0
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd2);
        hold(13);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        hold(9);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        // Reset mid-browse at idle 5, then a full timeout after release
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        hold(5);
        async_reset("browse");
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        hold(10);

        // Randomised traffic
        fe = 1'b0;
        ee = 1'b0;
        ei = 2'd0;
        for (int i = 0; i < 600; i++) begin
            ch_data = {16'($urandom), 32'($urandom)};
            if (fe) fe = ($urandom_range(0, 5) != 0);
            else    fe = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) ee = ~ee;
            if ($urandom_range(0, 15) == 0) ei = 2'($urandom_range(0, 3));
            step($urandom_range(0, 3) == 0, fe, 2'($urandom_range(0, 3)), ee, ei);
            if ($urandom_range(0, 249) == 0) async_reset("rand");
        end

        @(posedge mclk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
